// File: rtl/vxe_txnid_tracker_if.sv
// vxe_txnid_tracker_if: bundles the request, transaction, response and status
// signals of the transaction-Id tracker.
//   slave  modport : the tracker itself (drives the o_* signals)
//   master modport : the client/memory side (drives the i_* signals)
// Parameters must match those of the tracker instance the interface connects to.
interface vxe_txnid_tracker_if #(
    parameter int unsigned CLIENT_W  = 2,
    parameter int unsigned THREAD_W  = 3,
    parameter int unsigned ARG_W     = 1,
    parameter int unsigned MAX_OUTST = 16
);
    localparam int unsigned TXNID_W = CLIENT_W + THREAD_W + ARG_W;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTST + 1);

    // Request side
    logic                i_req_valid;
    logic                o_req_ready;
    logic [CLIENT_W-1:0] i_client_id;
    logic [THREAD_W-1:0] i_thread_id;
    logic [ARG_W-1:0]    i_argument;
    // Encoded transaction towards memory
    logic                o_txn_valid;
    logic                i_txn_ready;
    logic [TXNID_W-1:0]  o_txnid;
    // Response side (no backpressure)
    logic                i_rsp_valid;
    logic [TXNID_W-1:0]  i_rsp_txnid;
    logic                o_rsp_valid;
    logic [CLIENT_W-1:0] o_rsp_client_id;
    logic [THREAD_W-1:0] o_rsp_thread_id;
    logic [ARG_W-1:0]    o_rsp_argument;
    logic                o_rsp_err;
    // Status
    logic [CNT_W-1:0]    o_outstanding;
    logic                o_busy;

    modport slave (
        input  i_req_valid, i_client_id, i_thread_id, i_argument, i_txn_ready,
        input  i_rsp_valid, i_rsp_txnid,
        output o_req_ready, o_txn_valid, o_txnid,
        output o_rsp_valid, o_rsp_client_id, o_rsp_thread_id, o_rsp_argument, o_rsp_err,
        output o_outstanding, o_busy
    );

    modport master (
        output i_req_valid, i_client_id, i_thread_id, i_argument, i_txn_ready,
        output i_rsp_valid, i_rsp_txnid,
        input  o_req_ready, o_txn_valid, o_txnid,
        input  o_rsp_valid, o_rsp_client_id, o_rsp_thread_id, o_rsp_argument, o_rsp_err,
        input  o_outstanding, o_busy
    );
endinterface

// File: rtl/vxe_txnid_tracker.sv
// vxe_txnid_tracker: packs {client, thread, argument} into a transaction Id,
// tracks outstanding Ids in a pending bitmap, blocks duplicate Ids and caps the
// number of outstanding transactions; decodes returning response Ids and flags
// responses whose Id is not pending.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave modport of vxe_txnid_tracker_if (request, txn, response, status)
module vxe_txnid_tracker #(
    parameter int unsigned CLIENT_W  = 2,
    parameter int unsigned THREAD_W  = 3,
    parameter int unsigned ARG_W     = 1,
    parameter int unsigned MAX_OUTST = 16
) (
    input logic                  clk,
    input logic                  rst,
    vxe_txnid_tracker_if.slave   bus
);
    localparam int unsigned TXNID_W = CLIENT_W + THREAD_W + ARG_W;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTST + 1);
    localparam int unsigned NUM_IDS = 2 ** TXNID_W;

    logic [NUM_IDS-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic                txn_valid_q, txn_valid_d;
    logic [TXNID_W-1:0]  txnid_q, txnid_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [CLIENT_W-1:0] rsp_client_q, rsp_client_d;
    logic [THREAD_W-1:0] rsp_thread_q, rsp_thread_d;
    logic [ARG_W-1:0]    rsp_arg_q, rsp_arg_d;
    logic                rsp_err_q, rsp_err_d;

    logic [TXNID_W-1:0]  req_id;
    logic                can_load;
    logic                req_ready;
    logic                accept;
    logic                rsp_hit;
    logic                retire;

    always_comb begin
        req_id    = {bus.i_client_id, bus.i_thread_id, bus.i_argument};
        can_load  = !txn_valid_q || bus.i_txn_ready;
        req_ready = can_load && !pending_q[req_id] && (outst_q < CNT_W'(MAX_OUTST));
        accept    = bus.i_req_valid && req_ready;
        // Looked up in the pre-cycle bitmap, so a response for an Id accepted in
        // this same cycle is a stray.
        rsp_hit   = pending_q[bus.i_rsp_txnid];
        retire    = bus.i_rsp_valid && rsp_hit;

        pending_d = pending_q;
        if (retire) pending_d[bus.i_rsp_txnid] = 1'b0;
        if (accept) pending_d[req_id] = 1'b1;

        outst_d = outst_q;
        if (accept && !retire) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (retire && !accept) begin
            outst_d = outst_q - CNT_W'(1);
        end

        txn_valid_d = txn_valid_q;
        txnid_d     = txnid_q;
        if (accept) begin
            txn_valid_d = 1'b1;
            txnid_d     = req_id;
        end else if (bus.i_txn_ready) begin
            txn_valid_d = 1'b0;
        end

        rsp_valid_d  = bus.i_rsp_valid;
        rsp_err_d    = bus.i_rsp_valid && !rsp_hit;
        rsp_client_d = rsp_client_q;
        rsp_thread_d = rsp_thread_q;
        rsp_arg_d    = rsp_arg_q;
        if (bus.i_rsp_valid) begin
            {rsp_client_d, rsp_thread_d, rsp_arg_d} = bus.i_rsp_txnid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            outst_q      <= '0;
            txn_valid_q  <= 1'b0;
            txnid_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_client_q <= '0;
            rsp_thread_q <= '0;
            rsp_arg_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            outst_q      <= outst_d;
            txn_valid_q  <= txn_valid_d;
            txnid_q      <= txnid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_client_q <= rsp_client_d;
            rsp_thread_q <= rsp_thread_d;
            rsp_arg_q    <= rsp_arg_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.o_req_ready     = req_ready;
    assign bus.o_txn_valid     = txn_valid_q;
    assign bus.o_txnid         = txnid_q;
    assign bus.o_rsp_valid     = rsp_valid_q;
    assign bus.o_rsp_client_id = rsp_client_q;
    assign bus.o_rsp_thread_id = rsp_thread_q;
    assign bus.o_rsp_argument  = rsp_arg_q;
    assign bus.o_rsp_err       = rsp_err_q;
    assign bus.o_outstanding   = outst_q;
    assign bus.o_busy          = (outst_q != '0) || txn_valid_q;
endmodule
